// File: rtl/uart_fetch_ctrl_pkg.sv
// rtl/uart_fetch_ctrl_pkg.sv - shared state encoding, field widths and defaults for the UART program loader
package uart_fetch_ctrl_pkg;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_START,
    ST_RUN
  } state_t;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - pairs high/low bytes into 16-bit words and keeps the running XOR checksum
module uart_word_assembler
  import uart_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic              hi_en,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] csum
);

  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      csum_q <= '0;
    end else if (clear) begin
      hi_q   <= '0;
      csum_q <= '0;
    end else begin
      if (byte_en) csum_q <= csum_q ^ data;
      if (hi_en)   hi_q   <= data;
    end
  end

  // The low byte is taken straight from the bus so the word is ready on the accepting cycle.
  assign word = {hi_q, data};
  assign csum = csum_q;

endmodule

// File: rtl/uart_fetch_ctrl.sv
// rtl/uart_fetch_ctrl.sv - receives a framed program over UART, writes it to instruction memory and releases the CPU
module uart_fetch_ctrl
  import uart_fetch_ctrl_pkg::*;
#(
  parameter logic [7:0] START_BYTE  = START_BYTE_DEFAULT,
  parameter int         MEM_DEPTH   = 256,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        pc_load_en,
  output logic [15:0] pc_load_val,
  output logic        cpu_stall,
  output logic        done,
  output logic        err
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_W:0]    LEN_MAX  = (LEN_W + 1)'(MEM_DEPTH);

  state_t state, state_next;

  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] word_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [WORD_W-1:0] asm_word;
  logic [BYTE_W-1:0] asm_csum;

  logic asm_clear, asm_byte_en, asm_hi_en;
  logic len_load, wr_fire, set_err, clr_err;
  logic frame_active, timed_out, is_start;

  assign frame_active = in_frame(state);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timed_out    = frame_active && !rx_valid && (tmo_cnt == TMO_LAST);
  assign is_start     = rx_valid && (rx_data == START_BYTE);

  uart_word_assembler u_asm (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (asm_clear),
    .byte_en (asm_byte_en),
    .hi_en   (asm_hi_en),
    .data    (rx_data),
    .word    (asm_word),
    .csum    (asm_csum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    asm_clear   = 1'b0;
    asm_byte_en = 1'b0;
    asm_hi_en   = 1'b0;
    len_load    = 1'b0;
    wr_fire     = 1'b0;
    set_err     = 1'b0;
    clr_err     = 1'b0;
    if (timed_out) begin
      state_next = ST_IDLE;
      set_err    = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (is_start) begin
            state_next = ST_LEN_HI;
            asm_clear  = 1'b1;
            clr_err    = 1'b1;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            state_next  = ST_LEN_LO;
            asm_byte_en = 1'b1;
            asm_hi_en   = 1'b1;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            asm_byte_en = 1'b1;
            if ({1'b0, asm_word} > LEN_MAX) begin
              state_next = ST_IDLE;
              set_err    = 1'b1;
            end else begin
              len_load   = 1'b1;
              state_next = (asm_word == '0) ? ST_CHK : ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (rx_valid) begin
            state_next  = ST_DATA_LO;
            asm_byte_en = 1'b1;
            asm_hi_en   = 1'b1;
          end
        end
        ST_DATA_LO: begin
          if (rx_valid) begin
            asm_byte_en = 1'b1;
            wr_fire     = 1'b1;
            state_next  = (word_cnt == len_q - 16'd1) ? ST_CHK : ST_DATA_HI;
          end
        end
        ST_CHK: begin
          if (rx_valid) begin
            if (rx_data == asm_csum) begin
              state_next = ST_START;
            end else begin
              state_next = ST_IDLE;
              set_err    = 1'b1;
            end
          end
        end
        ST_START: state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= '0;
      word_cnt   <= '0;
      tmo_cnt    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= wr_fire;
      if (wr_fire) begin
        imem_addr  <= word_cnt;
        imem_wdata <= asm_word;
        word_cnt   <= word_cnt + 16'd1;
      end
      if (asm_clear) word_cnt <= '0;
      if (len_load)  len_q    <= asm_word;
      if (!frame_active || rx_valid) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

  assign pc_load_en  = (state == ST_START);
  assign pc_load_val = 16'h0000;
  assign cpu_stall   = (state != ST_RUN);
  assign done        = (state == ST_RUN);

endmodule
